// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side bundle for uart_tx_arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters' and UART's view.
interface uart_tx_arbiter_if;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  ack;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  wr_data;
  logic [1:0]  grant;
  logic        busy;

  modport slave  (input  req, req_data, req_last, tx_full,
                  output ack, wr_uart, wr_data, grant, busy);
  modport master (output req, req_data, req_last, tx_full,
                  input  ack, wr_uart, wr_data, grant, busy);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Three-requester byte arbiter feeding a UART TX FIFO. Round-robin by default;
// define UART_TX_ARB_PRIO_EN to give requester 0 fixed top priority.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0] r_state;
  logic [1:0] r_grant;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;

  logic       w_req_g;
  logic       w_last_g;
  logic [7:0] w_byte;
  logic [1:0] w_win;
  logic       w_beat;
  logic       w_done;
  logic       w_release;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  // Granted requester's lines; grant==3 (idle) selects nothing.
  always_comb begin
    w_req_g  = 1'b0;
    w_last_g = 1'b0;
    w_byte   = 8'h00;
    case (r_grant)
      2'd0: begin w_req_g = bus.req[0]; w_last_g = bus.req_last[0]; w_byte = bus.req_data[7:0];   end
      2'd1: begin w_req_g = bus.req[1]; w_last_g = bus.req_last[1]; w_byte = bus.req_data[15:8];  end
      2'd2: begin w_req_g = bus.req[2]; w_last_g = bus.req_last[2]; w_byte = bus.req_data[23:16]; end
      default: ;
    endcase
  end

`ifdef UART_TX_ARB_PRIO_EN
  // Requester 0 always wins; 1 and 2 alternate using the same pointer.
  always_comb begin
    w_win = 2'd0;
    if (bus.req[0])          w_win = 2'd0;
    else if (r_ptr == 2'd2)  w_win = bus.req[2] ? 2'd2 : 2'd1;
    else                     w_win = bus.req[1] ? 2'd1 : 2'd2;
  end
`else
  logic [1:0] w_p1;
  logic [1:0] w_p2;
  assign w_p1 = inc3(r_ptr);
  assign w_p2 = inc3(w_p1);

  // Later assignments override: the first hit in ptr, ptr+1, ptr+2 wins.
  always_comb begin
    w_win = w_p2;
    if (bit_at(bus.req, w_p1))  w_win = w_p1;
    if (bit_at(bus.req, r_ptr)) w_win = r_ptr;
  end
`endif

  assign w_beat    = (r_state == S_SEND) & w_req_g & ~bus.tx_full;
  assign w_done    = w_beat & (w_last_g | (({1'b0, r_cnt} + 9'd1) == 9'(MAX_BURST)));
  assign w_release = (r_state == S_SEND) & (~w_req_g | w_done);

  assign bus.wr_uart = w_beat;
  assign bus.wr_data = w_beat ? w_byte : 8'h00;
  assign bus.ack     = w_beat ? (3'b001 << r_grant) : 3'b000;
  assign bus.grant   = r_grant;
  assign bus.busy    = (r_state == S_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 2'd3;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_state <= S_SEND;
            r_grant <= w_win;
            r_cnt   <= 8'd0;
          end
        end
        default: begin
          // Abandon, end of message and burst limit all release the same way.
          if (w_release) begin
            r_state <= S_IDLE;
            r_grant <= 2'd3;
            r_ptr   <= inc3(r_grant);
          end else if (w_beat) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (MAX_BURST=4); expected
// grant orders follow the arbitration mode selected by UART_TX_ARB_PRIO_EN.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if u_if();

  uart_tx_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  typedef struct {
    int          id;
    logic        rn;
    logic [2:0]  rq;
    logic [23:0] d;
    logic [2:0]  l;
    logic        tf;
    logic        wr;
    logic [7:0]  wd;
    logic [2:0]  ack;
    logic [1:0]  gr;
    logic        busy;
  } vec_t;

  vec_t vq[$];
  int   sec = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic av(input logic rn, input logic [2:0] rq, input logic [23:0] d,
                    input logic [2:0] l, input logic tf, input logic wr,
                    input logic [7:0] wd, input logic [2:0] ack,
                    input logic [1:0] gr, input logic busy);
    vec_t v;
    v.id = sec * 100 + vq.size() % 100;
    v.rn = rn; v.rq = rq; v.d = d; v.l = l; v.tf = tf;
    v.wr = wr; v.wd = wd; v.ack = ack; v.gr = gr; v.busy = busy;
    vq.push_back(v);
  endtask

  task automatic rst_v();
    av(1'b0, 3'b000, 24'h0, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 2'd3, 1'b0);
  endtask

  task automatic idle_v(input logic [2:0] rq, input logic [23:0] d, input logic [2:0] l);
    av(1'b1, rq, d, l, 1'b0, 1'b0, 8'h00, 3'b000, 2'd3, 1'b0);
  endtask

  task automatic beat_v(input logic [2:0] rq, input logic [23:0] d, input logic [2:0] l,
                        input logic [1:0] g);
    av(1'b1, rq, d, l, 1'b0, 1'b1, d[8*g +: 8], 3'b001 << g, g, 1'b1);
  endtask

  task automatic stall_v(input logic [2:0] rq, input logic [23:0] d, input logic [2:0] l,
                         input logic [1:0] g);
    av(1'b1, rq, d, l, 1'b1, 1'b0, 8'h00, 3'b000, g, 1'b1);
  endtask

  task automatic drive(input logic rn, input logic [2:0] rq, input logic [23:0] d,
                       input logic [2:0] l, input logic tf);
    rst_n = rn;
    u_if.req = rq; u_if.req_data = d; u_if.req_last = l; u_if.tx_full = tf;
  endtask

  task automatic chk(input int id, input logic wr, input logic [7:0] wd,
                     input logic [2:0] ack, input logic [1:0] gr, input logic busy);
    logic [14:0] act, exp;
    act = {u_if.wr_uart, u_if.wr_data, u_if.ack, u_if.grant, u_if.busy};
    exp = {wr, wd, ack, gr, busy};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d {wr,data,ack,grant,busy}: got %b/%h/%b/%0d/%b expected %b/%h/%b/%0d/%b",
               id, act[14], act[13:6], act[5:3], act[2:1], act[0],
               wr, wd, ack, gr, busy);
    end
  endtask

  logic [1:0] g_all[4];
  logic [1:0] g_02[4];
  logic [1:0] g_a;

  initial begin
`ifdef UART_TX_ARB_PRIO_EN
    g_all = '{2'd0, 2'd0, 2'd0, 2'd0};
    g_02  = '{2'd0, 2'd0, 2'd0, 2'd0};
    g_a   = 2'd0;
`else
    g_all = '{2'd0, 2'd1, 2'd2, 2'd0};
    g_02  = '{2'd0, 2'd2, 2'd0, 2'd2};
    g_a   = 2'd2;
`endif
    drive(1'b0, 3'b000, 24'h0, 3'b000, 1'b0);

    // 1: reset state, then "ABC" from requester 1; pointer must end at 2.
    sec = 1;
    rst_v();
    idle_v(3'b010, 24'h004100, 3'b000);
    beat_v(3'b010, 24'h004100, 3'b000, 2'd1);
    beat_v(3'b010, 24'h004200, 3'b000, 2'd1);
    beat_v(3'b010, 24'h004300, 3'b010, 2'd1);
    idle_v(3'b101, 24'h500030, 3'b101);
    beat_v(3'b101, 24'h500030, 3'b101, g_a);
    idle_v(3'b000, 24'h0, 3'b000);

    // 2: all three requesting one-byte messages.
    sec = 2;
    rst_v();
    for (int k = 0; k < 4; k++) begin
      idle_v(3'b111, 24'h121110, 3'b111);
      beat_v(3'b111, 24'h121110, 3'b111, g_all[k]);
    end

    // 3: five-cycle tx_full stall in the middle of a message.
    sec = 3;
    rst_v();
    idle_v(3'b010, 24'h005800, 3'b000);
    beat_v(3'b010, 24'h005800, 3'b000, 2'd1);
    for (int k = 0; k < 5; k++) stall_v(3'b010, 24'h005900, 3'b000, 2'd1);
    beat_v(3'b010, 24'h005900, 3'b000, 2'd1);
    beat_v(3'b010, 24'h005A00, 3'b010, 2'd1);
    idle_v(3'b000, 24'h0, 3'b000);

    // 4: burst limit on requester 2, requester 1 served in between, then abandon.
    sec = 4;
    rst_v();
    idle_v(3'b100, 24'h600000, 3'b000);
    beat_v(3'b100, 24'h600000, 3'b000, 2'd2);
    beat_v(3'b110, 24'h617000, 3'b010, 2'd2);
    beat_v(3'b110, 24'h627000, 3'b010, 2'd2);
    beat_v(3'b110, 24'h637000, 3'b010, 2'd2);
    idle_v(3'b110, 24'h647000, 3'b010);
    beat_v(3'b110, 24'h647000, 3'b010, 2'd1);
    idle_v(3'b100, 24'h640000, 3'b000);
    beat_v(3'b100, 24'h640000, 3'b000, 2'd2);
    av(1'b1, 3'b000, 24'h0, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 2'd2, 1'b1);
    idle_v(3'b000, 24'h0, 3'b000);

    // 5: requesters 0 and 2 pending at every arbitration.
    sec = 5;
    rst_v();
    for (int k = 0; k < 4; k++) begin
      idle_v(3'b101, 24'h500030, 3'b101);
      beat_v(3'b101, 24'h500030, 3'b101, g_02[k]);
    end

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].rn, vq[i].rq, vq[i].d, vq[i].l, vq[i].tf);
      @(negedge clk);
      chk(vq[i].id, vq[i].wr, vq[i].wd, vq[i].ack, vq[i].gr, vq[i].busy);
    end

    // 6: asynchronous reset while byte 2 is on the bus.
    @(posedge clk); #1; drive(1'b0, 3'b000, 24'h0, 3'b000, 1'b0);
    @(posedge clk); #1; drive(1'b1, 3'b010, 24'h004100, 3'b000, 1'b0);
    @(negedge clk); chk(600, 1'b0, 8'h00, 3'b000, 2'd3, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk(601, 1'b1, 8'h41, 3'b010, 2'd1, 1'b1);
    @(posedge clk); #1; u_if.req_data = 24'h004200;
    @(negedge clk); chk(602, 1'b1, 8'h42, 3'b010, 2'd1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk(603, 1'b0, 8'h00, 3'b000, 2'd3, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk(604, 1'b0, 8'h00, 3'b000, 2'd3, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk(605, 1'b0, 8'h00, 3'b000, 2'd3, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk(606, 1'b1, 8'h42, 3'b010, 2'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
